// File: rtl/trunc_mult_pkg.sv
// Shared types and helpers for the sequential truncated multiplier.
// States, and the partial-product column mask used in truncated mode.
package trunc_mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Upper bound on WIDTH that keep_mask can describe.
  localparam int MAX_WIDTH = 32;

  // A bit is set for each product column that a row shifted by 'shift' occupies
  // and that lies at or above the truncation boundary width-keep_cols.
  function automatic logic [2*MAX_WIDTH-1:0] keep_mask(input int width,
                                                       input int keep_cols,
                                                       input int shift);
    logic [2*MAX_WIDTH-1:0] m;
    m = '0;
    for (int c = 0; c < 2*MAX_WIDTH; c++) begin
      m[c] = (c >= width - keep_cols) && (c >= shift) && (c < shift + width);
    end
    return m;
  endfunction

endpackage

// File: rtl/trunc_pp_row.sv
// One partial-product row of the shift-add multiplier: a shifted by 'shift'
// when the multiplier bit is set, with discarded low columns cleared in truncated mode.
module trunc_pp_row
  import trunc_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int KEEP_COLS = 3,
  parameter int SHIFT_W   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               exact,
  output logic [2*WIDTH-1:0] row
);

  logic [2*WIDTH-1:0] mask;
  logic [2*WIDTH-1:0] shifted;

  always_comb begin
    mask    = (2*WIDTH)'(keep_mask(WIDTH, KEEP_COLS, int'(shift)));
    shifted = {{WIDTH{1'b0}}, a} << shift;
    row     = '0;
    if (b) begin
      row = exact ? shifted : (shifted & mask);
    end
  end

endmodule

// File: rtl/trunc_mult_seq.sv
// Iterative shift-add unsigned multiplier returning the upper WIDTH product bits,
// either exact or truncated with a constant bias correction; one operation in flight.
module trunc_mult_seq
  import trunc_mult_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int KEEP_COLS = 3,
  parameter int CORR      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_exact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               exact_r;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] row;
  logic [2*WIDTH-1:0] corr_add;
  logic [CNT_W-1:0]   cnt;
  logic               last;

  assign last     = (cnt == CNT_W'(WIDTH - 1));
  assign corr_add = (last && !exact_r) ? (2*WIDTH)'(CORR) : '0;
  assign out_p    = acc[2*WIDTH-1:WIDTH];

  trunc_pp_row #(
    .WIDTH     (WIDTH),
    .KEEP_COLS (KEEP_COLS),
    .SHIFT_W   (CNT_W)
  ) u_row (
    .a     (a_r),
    .b     (b_r[cnt]),
    .shift (cnt),
    .exact (exact_r),
    .row   (row)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) next_state = S_RUN;
      end
      S_RUN: begin
        if (last) next_state = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  // The correction is folded into the final row so the result is ready on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      exact_r <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r     <= in_a;
            b_r     <= in_b;
            exact_r <= in_exact;
            acc     <= '0;
            cnt     <= '0;
          end
        end
        S_RUN: begin
          acc <= acc + row + corr_add;
          cnt <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trunc_mult_seq.sv
// Directed and randomized checks of trunc_mult_seq at WIDTH=8, KEEP_COLS=3, CORR=16.
module tb_trunc_mult_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_exact;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       busy;

  int total = 0;
  int bad   = 0;

  trunc_mult_seq #(.WIDTH(8), .KEEP_COLS(3), .CORR(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] ref_mult(input logic [7:0] a, input logic [7:0] b, input logic e);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (a[i] && b[j] && (e || (i + j >= 5))) s = s + (16'd1 << (i + j));
    if (!e) s = s + 16'd16;
    return s[15:8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand set, then scrambles the inputs and waits (bounded) for out_valid.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic e, output int lat);
    in_a = a; in_b = b; in_exact = e; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_a = 8'h5A; in_b = 8'hA5; in_exact = ~e;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_exact = 1'b0; out_ready = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    total++; if (out_p !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_p: got %h want 00", out_p); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] va [10] = '{8'hC0, 8'hC0, 8'hE0, 8'hE0, 8'hFF, 8'hFF, 8'h80, 8'h10, 8'h1F, 8'h01};
    logic [7:0] vb [10] = '{8'h40, 8'h40, 8'h60, 8'h60, 8'hFF, 8'hFF, 8'h80, 8'h10, 8'h1F, 8'h01};
    logic       ve [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] vp [10] = '{8'h30, 8'h30, 8'h54, 8'h54, 8'hFE, 8'hFD, 8'h40, 8'h01, 8'h03, 8'h00};
    int lat;
    for (int k = 0; k < 10; k++) begin
      start_op(va[k], vb[k], ve[k], lat);
      total++; if (lat !== 9) begin bad++; $display("[TB] FAIL basic_latency[%0d]: got %0d want 9", k, lat); end
      total++; if (out_p !== vp[k]) begin bad++; $display("[TB] FAIL basic_out_p[%0d]: got %h want %h", k, out_p, vp[k]); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy[%0d]: got %b want 1", k, busy); end
      release_out();
      total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_idle[%0d]: got %b want 1", k, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'hE0, 8'h60, 1'b1, lat);
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL bp_latency: got %0d want 9", lat); end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF; in_exact = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", k, out_valid); end
      total++; if (out_p !== 8'h54) begin bad++; $display("[TB] FAIL bp_hold_p[%0d]: got %h want 54", k, out_p); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
    end
    in_valid = 1'b0;
    release_out();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_release_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    start_op(8'h10, 8'h10, 1'b1, lat);
    total++; if (out_p !== 8'h01) begin bad++; $display("[TB] FAIL bp_next_op: got %h want 01", out_p); end
    release_out();
  endtask

  task automatic test_midreset();
    int lat;
    logic spurious;
    in_a = 8'hFF; in_b = 8'hFF; in_exact = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL mr_running: got %b want 1", busy); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mr_out_valid: got %b want 0", out_valid); end
    total++; if (out_p !== 8'h00) begin bad++; $display("[TB] FAIL mr_out_p: got %h want 00", out_p); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mr_in_ready: got %b want 1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL mr_busy: got %b want 0", busy); end
    spurious = 1'b0;
    repeat (12) begin
      tick();
      if (out_valid !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious !== 1'b0) begin bad++; $display("[TB] FAIL mr_no_output: got %b want 0", spurious); end
    start_op(8'h01, 8'h01, 1'b0, lat);
    total++; if (lat !== 9) begin bad++; $display("[TB] FAIL mr_next_latency: got %0d want 9", lat); end
    total++; if (out_p !== 8'h00) begin bad++; $display("[TB] FAIL mr_next_p: got %h want 00", out_p); end
    release_out();
    start_op(8'hFF, 8'hFF, 1'b0, lat);
    total++; if (out_p !== 8'hFD) begin bad++; $display("[TB] FAIL mr_after_p: got %h want FD", out_p); end
    release_out();
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] exp;
    int ops;
    ops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_exact  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (in_ready && out_valid) begin
        total++; bad++;
        $display("[TB] FAIL rnd_exclusive: got in_ready=1 out_valid=1 want not both");
      end
      if (in_valid && in_ready) begin
        total++;
        if (q.size() != 0) begin bad++; $display("[TB] FAIL rnd_in_flight: got %0d want 0", q.size()); end
        q.push_back(ref_mult(in_a, in_b, in_exact));
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("[TB] FAIL rnd_unexpected: got out_valid want none pending");
        end else begin
          exp = q.pop_front();
          ops++;
          if (out_p !== exp) begin bad++; $display("[TB] FAIL rnd_result: got %h want %h", out_p, exp); end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 30 && q.size() != 0; k++) begin
      if (out_valid) begin
        total++;
        exp = q.pop_front();
        if (out_p !== exp) begin bad++; $display("[TB] FAIL rnd_drain: got %h want %h", out_p, exp); end
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL rnd_leftover: got %0d want 0", q.size()); end
    $display("[TB] random ops completed: %0d", ops);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
